// File: rtl/gsensor_spi_sequencer.sv
// ADXL345-style sequencer: configures the sensor once, then serves host register accesses and 6-byte sample reads.
// Optional GSENSOR_POLL_TIMER_EN macro adds a periodic poll trigger alongside the INT2 interrupt.
module gsensor_spi_sequencer #(
   parameter logic [15:0] START_DLY = 16'd2000,
   parameter logic [15:0] POLL_DIV  = 16'd40000
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iG_INT2,
   input  logic        iHOST_REQ,
   input  logic        iHOST_WR,
   input  logic [5:0]  iHOST_ADDR,
   input  logic [7:0]  iHOST_WDATA,
   output logic        oHOST_ACK,
   output logic [7:0]  oHOST_RDATA,
   output logic        oCMD_VALID,
   output logic        oCMD_WR,
   output logic [5:0]  oCMD_ADDR,
   output logic [7:0]  oCMD_WDATA,
   input  logic        iCMD_READY,
   input  logic        iRSP_VALID,
   input  logic [7:0]  iRSP_DATA,
   output logic [15:0] oDATA_X,
   output logic [15:0] oDATA_Y,
   output logic [15:0] oDATA_Z,
   output logic        oSAMPLE_VALID,
   output logic        oCFG_DONE,
   output logic        oOVERRUN
);

   typedef enum logic [2:0] {
      WAIT_START = 3'd0,
      CFG_ISSUE  = 3'd1,
      CFG_WAIT   = 3'd2,
      IDLE       = 3'd3,
      HOST_ISSUE = 3'd4,
      HOST_WAIT  = 3'd5,
      RD_ISSUE   = 3'd6,
      RD_WAIT    = 3'd7
   } state_t;

   // Configuration write table: {register address, value}.
   function automatic logic [13:0] cfg_entry(input logic [2:0] idx);
      logic [13:0] e;
      case (idx)
         3'd0:    e = {6'h31, 8'h40};
         3'd1:    e = {6'h2C, 8'h09};
         3'd2:    e = {6'h2F, 8'h80};
         3'd3:    e = {6'h2E, 8'h80};
         3'd4:    e = {6'h2D, 8'h08};
         default: e = 14'd0;
      endcase
      return e;
   endfunction

   state_t      state_q, state_d;
   logic [15:0] dly_cnt_q, dly_cnt_d;
   logic [2:0]  cfg_idx_q, cfg_idx_d;
   logic [2:0]  byte_idx_q, byte_idx_d;
   logic [2:0]  int_sync_q;
   logic        pend_q, pend_d;
   logic        overrun_q, overrun_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic        cmd_wr_q, cmd_wr_d;
   logic [5:0]  cmd_addr_q, cmd_addr_d;
   logic [7:0]  cmd_wdata_q, cmd_wdata_d;
   logic        host_wr_q, host_wr_d;
   logic        host_ack_q, host_ack_d;
   logic [7:0]  host_rdata_q, host_rdata_d;
   logic [7:0]  shadow_q [0:4];
   logic [7:0]  shadow_d [0:4];
   logic [15:0] data_x_q, data_x_d;
   logic [15:0] data_y_q, data_y_d;
   logic [15:0] data_z_q, data_z_d;
   logic        sample_valid_q, sample_valid_d;
   logic        cfg_done_q, cfg_done_d;

   logic        accept_s;
   logic        pend_clr_s;
   logic        int_edge_s;
   logic        trig_s;

   assign accept_s   = cmd_valid_q & iCMD_READY;
   assign int_edge_s = int_sync_q[1] & ~int_sync_q[2];

`ifdef GSENSOR_POLL_TIMER_EN
   logic [15:0] poll_cnt_q;
   logic        poll_tick_s;

   assign poll_tick_s = cfg_done_q & (poll_cnt_q == (POLL_DIV - 16'd1));
   assign trig_s      = cfg_done_q & (int_edge_s | poll_tick_s);

   // Free-running poll period counter, held at zero until configuration completes.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         poll_cnt_q <= 16'd0;
      end else if (!cfg_done_q || poll_tick_s) begin
         poll_cnt_q <= 16'd0;
      end else begin
         poll_cnt_q <= poll_cnt_q + 16'd1;
      end
   end
`else
   logic poll_div_unused_s;

   assign poll_div_unused_s = ^POLL_DIV;
   assign trig_s            = cfg_done_q & int_edge_s;
`endif

   // INT2 synchroniser; bit 2 keeps the previous synchronised level for edge detection.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         int_sync_q <= 3'b000;
      end else begin
         int_sync_q <= {int_sync_q[1:0], iG_INT2};
      end
   end

   // Single-entry pending request; a trigger that finds it still occupied is a lost sample.
   always_comb begin
      pend_d    = pend_q;
      overrun_d = overrun_q;
      if (trig_s) begin
         pend_d = 1'b1;
         if (pend_q && !pend_clr_s) begin
            overrun_d = 1'b1;
         end else begin
            overrun_d = overrun_q;
         end
      end else if (pend_clr_s) begin
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q;
      end
   end

   // Sequencer next-state and registered-output logic.
   always_comb begin
      state_d        = state_q;
      dly_cnt_d      = dly_cnt_q;
      cfg_idx_d      = cfg_idx_q;
      byte_idx_d     = byte_idx_q;
      pend_clr_s     = 1'b0;
      cmd_valid_d    = cmd_valid_q;
      cmd_wr_d       = cmd_wr_q;
      cmd_addr_d     = cmd_addr_q;
      cmd_wdata_d    = cmd_wdata_q;
      host_wr_d      = host_wr_q;
      host_ack_d     = 1'b0;
      host_rdata_d   = host_rdata_q;
      shadow_d       = shadow_q;
      data_x_d       = data_x_q;
      data_y_d       = data_y_q;
      data_z_d       = data_z_q;
      sample_valid_d = 1'b0;
      cfg_done_d     = cfg_done_q;

      case (state_q)
         WAIT_START: begin
            if (({1'b0, dly_cnt_q} + 17'd1) >= {1'b0, START_DLY}) begin
               state_d                   = CFG_ISSUE;
               cfg_idx_d                 = 3'd0;
               cmd_valid_d               = 1'b1;
               cmd_wr_d                  = 1'b1;
               {cmd_addr_d, cmd_wdata_d} = cfg_entry(3'd0);
            end else begin
               dly_cnt_d = dly_cnt_q + 16'd1;
            end
         end
         CFG_ISSUE: begin
            if (accept_s) begin
               cmd_valid_d = 1'b0;
               state_d     = CFG_WAIT;
            end else begin
               state_d = CFG_ISSUE;
            end
         end
         CFG_WAIT: begin
            if (iRSP_VALID) begin
               if (cfg_idx_q == 3'd4) begin
                  state_d    = IDLE;
                  cfg_done_d = 1'b1;
               end else begin
                  state_d                   = CFG_ISSUE;
                  cfg_idx_d                 = cfg_idx_q + 3'd1;
                  cmd_valid_d               = 1'b1;
                  cmd_wr_d                  = 1'b1;
                  {cmd_addr_d, cmd_wdata_d} = cfg_entry(cfg_idx_q + 3'd1);
               end
            end else begin
               state_d = CFG_WAIT;
            end
         end
         IDLE: begin
            // The ack cycle is skipped so a host still holding its request is not served twice.
            if (iHOST_REQ && !host_ack_q) begin
               state_d     = HOST_ISSUE;
               host_wr_d   = iHOST_WR;
               cmd_valid_d = 1'b1;
               cmd_wr_d    = iHOST_WR;
               cmd_addr_d  = iHOST_ADDR;
               cmd_wdata_d = iHOST_WDATA;
            end else if (pend_q) begin
               state_d     = RD_ISSUE;
               pend_clr_s  = 1'b1;
               byte_idx_d  = 3'd0;
               cmd_valid_d = 1'b1;
               cmd_wr_d    = 1'b0;
               cmd_addr_d  = 6'h32;
               cmd_wdata_d = 8'h00;
            end else begin
               state_d = IDLE;
            end
         end
         HOST_ISSUE: begin
            if (accept_s) begin
               cmd_valid_d = 1'b0;
               state_d     = HOST_WAIT;
            end else begin
               state_d = HOST_ISSUE;
            end
         end
         HOST_WAIT: begin
            if (iRSP_VALID) begin
               state_d    = IDLE;
               host_ack_d = 1'b1;
               if (!host_wr_q) begin
                  host_rdata_d = iRSP_DATA;
               end else begin
                  host_rdata_d = host_rdata_q;
               end
            end else begin
               state_d = HOST_WAIT;
            end
         end
         RD_ISSUE: begin
            if (accept_s) begin
               cmd_valid_d = 1'b0;
               state_d     = RD_WAIT;
            end else begin
               state_d = RD_ISSUE;
            end
         end
         RD_WAIT: begin
            if (iRSP_VALID) begin
               if (byte_idx_q == 3'd5) begin
                  state_d        = IDLE;
                  data_x_d       = {shadow_q[1], shadow_q[0]};
                  data_y_d       = {shadow_q[3], shadow_q[2]};
                  data_z_d       = {iRSP_DATA, shadow_q[4]};
                  sample_valid_d = 1'b1;
               end else begin
                  state_d              = RD_ISSUE;
                  shadow_d[byte_idx_q] = iRSP_DATA;
                  byte_idx_d           = byte_idx_q + 3'd1;
                  cmd_valid_d          = 1'b1;
                  cmd_wr_d             = 1'b0;
                  cmd_addr_d           = 6'h33 + {3'b000, byte_idx_q};
                  cmd_wdata_d          = 8'h00;
               end
            end else begin
               state_d = RD_WAIT;
            end
         end
         default: begin
            state_d     = WAIT_START;
            cmd_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q        <= WAIT_START;
         dly_cnt_q      <= 16'd0;
         cfg_idx_q      <= 3'd0;
         byte_idx_q     <= 3'd0;
         pend_q         <= 1'b0;
         overrun_q      <= 1'b0;
         cmd_valid_q    <= 1'b0;
         cmd_wr_q       <= 1'b0;
         cmd_addr_q     <= 6'd0;
         cmd_wdata_q    <= 8'd0;
         host_wr_q      <= 1'b0;
         host_ack_q     <= 1'b0;
         host_rdata_q   <= 8'd0;
         for (int i = 0; i < 5; i++) begin
            shadow_q[i] <= 8'd0;
         end
         data_x_q       <= 16'd0;
         data_y_q       <= 16'd0;
         data_z_q       <= 16'd0;
         sample_valid_q <= 1'b0;
         cfg_done_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         dly_cnt_q      <= dly_cnt_d;
         cfg_idx_q      <= cfg_idx_d;
         byte_idx_q     <= byte_idx_d;
         pend_q         <= pend_d;
         overrun_q      <= overrun_d;
         cmd_valid_q    <= cmd_valid_d;
         cmd_wr_q       <= cmd_wr_d;
         cmd_addr_q     <= cmd_addr_d;
         cmd_wdata_q    <= cmd_wdata_d;
         host_wr_q      <= host_wr_d;
         host_ack_q     <= host_ack_d;
         host_rdata_q   <= host_rdata_d;
         shadow_q       <= shadow_d;
         data_x_q       <= data_x_d;
         data_y_q       <= data_y_d;
         data_z_q       <= data_z_d;
         sample_valid_q <= sample_valid_d;
         cfg_done_q     <= cfg_done_d;
      end
   end

   assign oCMD_VALID    = cmd_valid_q;
   assign oCMD_WR       = cmd_wr_q;
   assign oCMD_ADDR     = cmd_addr_q;
   assign oCMD_WDATA    = cmd_wdata_q;
   assign oHOST_ACK     = host_ack_q;
   assign oHOST_RDATA   = host_rdata_q;
   assign oDATA_X       = data_x_q;
   assign oDATA_Y       = data_y_q;
   assign oDATA_Z       = data_z_q;
   assign oSAMPLE_VALID = sample_valid_q;
   assign oCFG_DONE     = cfg_done_q;
   assign oOVERRUN      = overrun_q;

endmodule

// File: tb/tb_gsensor_spi_sequencer.sv
// Scoreboard bench for gsensor_spi_sequencer: a sensor/byte-engine model answers commands,
// expected commands, samples and host replies are queued by the stimulus and checked by monitors.
module tb_gsensor_spi_sequencer;

   localparam logic [15:0] START_DLY = 16'd20;

   logic        iCLK, iRST, iG_INT2;
   logic        iHOST_REQ, iHOST_WR;
   logic [5:0]  iHOST_ADDR;
   logic [7:0]  iHOST_WDATA;
   logic        oHOST_ACK;
   logic [7:0]  oHOST_RDATA;
   logic        oCMD_VALID, oCMD_WR;
   logic [5:0]  oCMD_ADDR;
   logic [7:0]  oCMD_WDATA;
   logic        iCMD_READY, iRSP_VALID;
   logic [7:0]  iRSP_DATA;
   logic [15:0] oDATA_X, oDATA_Y, oDATA_Z;
   logic        oSAMPLE_VALID, oCFG_DONE, oOVERRUN;

   gsensor_spi_sequencer #(.START_DLY(START_DLY), .POLL_DIV(16'd1000)) dut (
      .iCLK(iCLK), .iRST(iRST), .iG_INT2(iG_INT2),
      .iHOST_REQ(iHOST_REQ), .iHOST_WR(iHOST_WR), .iHOST_ADDR(iHOST_ADDR), .iHOST_WDATA(iHOST_WDATA),
      .oHOST_ACK(oHOST_ACK), .oHOST_RDATA(oHOST_RDATA),
      .oCMD_VALID(oCMD_VALID), .oCMD_WR(oCMD_WR), .oCMD_ADDR(oCMD_ADDR), .oCMD_WDATA(oCMD_WDATA),
      .iCMD_READY(iCMD_READY), .iRSP_VALID(iRSP_VALID), .iRSP_DATA(iRSP_DATA),
      .oDATA_X(oDATA_X), .oDATA_Y(oDATA_Y), .oDATA_Z(oDATA_Z),
      .oSAMPLE_VALID(oSAMPLE_VALID), .oCFG_DONE(oCFG_DONE), .oOVERRUN(oOVERRUN)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   int checks = 0;
   int errors = 0;
   logic [14:0] exp_cmd_q [$];
   logic [47:0] exp_smp_q [$];
   logic [7:0]  exp_host_q [$];
   logic [7:0]  smp_bytes_q [$];
   logic [7:0]  regs [0:63];
   logic [7:0]  host_rdata_model = 8'h00;
   int lat = 3;
   int cmd_seen = 0;
   int smp_rsp_cnt = 0;
   int smp_seen = 0;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [47:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %0h want nothing", name, act);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge iCLK);
         #2;
      end
   endtask

   // Command monitor
   initial forever begin
      @(negedge iCLK);
      if (!iRST && oCMD_VALID && iCMD_READY) begin
         cmd_seen++;
         if (exp_cmd_q.size() == 0) fail_now("unexpected_cmd", {33'd0, oCMD_WR, oCMD_ADDR, oCMD_WDATA});
         else check("cmd", {33'd0, oCMD_WR, oCMD_ADDR, oCMD_WDATA}, {33'd0, exp_cmd_q.pop_front()});
      end
   end

   // Sample monitor
   initial forever begin
      @(negedge iCLK);
      if (oSAMPLE_VALID) begin
         smp_seen++;
         if (exp_smp_q.size() == 0) fail_now("unexpected_sample", {oDATA_X, oDATA_Y, oDATA_Z});
         else check("sample_xyz", {oDATA_X, oDATA_Y, oDATA_Z}, exp_smp_q.pop_front());
      end
   end

   // Host reply monitor
   initial forever begin
      @(negedge iCLK);
      if (oHOST_ACK) begin
         if (exp_host_q.size() == 0) fail_now("unexpected_host_ack", {40'd0, oHOST_RDATA});
         else check("host_rdata", {40'd0, oHOST_RDATA}, {40'd0, exp_host_q.pop_front()});
      end
   end

   // Byte-engine and sensor model
   initial begin
      bit          busy, acc, acc_wr, rsp_smp, pend_smp;
      int          dly;
      logic [5:0]  acc_addr;
      logic [7:0]  acc_wd, rsp_byte;
      busy = 0; dly = 0; pend_smp = 0; rsp_byte = 8'h00;
      iRSP_VALID = 1'b0;
      iRSP_DATA  = 8'h00;
      forever begin
         @(negedge iCLK);
         acc      = !iRST && oCMD_VALID && iCMD_READY;
         acc_wr   = oCMD_WR;
         acc_addr = oCMD_ADDR;
         acc_wd   = oCMD_WDATA;
         @(posedge iCLK);
         #1;
         iRSP_VALID = 1'b0;
         if (iRST) begin
            busy = 0;
         end else begin
            if (busy) begin
               if (dly <= 1) begin
                  iRSP_VALID = 1'b1;
                  iRSP_DATA  = rsp_byte;
                  busy       = 0;
                  if (pend_smp) smp_rsp_cnt++;
               end else begin
                  dly--;
               end
            end
            if (acc) begin
               busy     = 1;
               dly      = lat;
               rsp_smp  = !acc_wr && acc_addr >= 6'h32 && acc_addr <= 6'h37;
               pend_smp = rsp_smp;
               if (acc_wr) begin
                  regs[acc_addr] = acc_wd;
                  rsp_byte = 8'($urandom);
               end else if (rsp_smp) begin
                  rsp_byte = (smp_bytes_q.size() > 0) ? smp_bytes_q.pop_front() : 8'($urandom);
               end else begin
                  rsp_byte = regs[acc_addr];
               end
            end
         end
      end
   end

   task automatic push_cfg();
      exp_cmd_q.push_back({1'b1, 6'h31, 8'h40});
      exp_cmd_q.push_back({1'b1, 6'h2C, 8'h09});
      exp_cmd_q.push_back({1'b1, 6'h2F, 8'h80});
      exp_cmd_q.push_back({1'b1, 6'h2E, 8'h80});
      exp_cmd_q.push_back({1'b1, 6'h2D, 8'h08});
   endtask

   task automatic push_sample(input logic [47:0] bytes);
      logic [7:0] b [6];
      for (int i = 0; i < 6; i++) begin
         b[i] = bytes[47 - 8*i -: 8];
         smp_bytes_q.push_back(b[i]);
         exp_cmd_q.push_back({1'b0, 6'h32 + 6'(i), 8'h00});
      end
      exp_smp_q.push_back({b[1], b[0], b[3], b[2], b[5], b[4]});
   endtask

   task automatic int_edge();
      iG_INT2 = 1'b1;
      tick(3);
      iG_INT2 = 1'b0;
      tick(3);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_cmd_q.size() + exp_smp_q.size() + exp_host_q.size()) != 0 && n < 2000) begin
         tick(1);
         n++;
      end
      if (n >= 2000) fail_now(name, 48'(exp_cmd_q.size()));
      tick(4);
   endtask

   task automatic wait_ack(input string name);
      int n = 0;
      do begin
         tick(1);
         n++;
      end while (!oHOST_ACK && n < 200);
      if (!oHOST_ACK) fail_now(name, 48'(n));
   endtask

   task automatic host_access(input logic wr, input logic [5:0] addr, input logic [7:0] wd);
      exp_cmd_q.push_back({wr, addr, wd});
      if (!wr) host_rdata_model = regs[addr];
      exp_host_q.push_back(host_rdata_model);
      iHOST_WR = wr; iHOST_ADDR = addr; iHOST_WDATA = wd; iHOST_REQ = 1'b1;
      wait_ack("host_ack_timeout");
      iHOST_REQ = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_valid"}, 48'(oCMD_VALID), 48'd0);
      check({tag, "_cmd_fields"}, {33'd0, oCMD_WR, oCMD_ADDR, oCMD_WDATA}, 48'd0);
      check({tag, "_host_ack"}, 48'(oHOST_ACK), 48'd0);
      check({tag, "_host_rdata"}, 48'(oHOST_RDATA), 48'd0);
      check({tag, "_data_xyz"}, {oDATA_X, oDATA_Y, oDATA_Z}, 48'd0);
      check({tag, "_sample_valid"}, 48'(oSAMPLE_VALID), 48'd0);
      check({tag, "_cfg_done"}, 48'(oCFG_DONE), 48'd0);
      check({tag, "_overrun"}, 48'(oOVERRUN), 48'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, c0, s0;
      logic [7:0] wd;
      logic [5:0] ad;
      iRST = 1'b1; iG_INT2 = 1'b0; iHOST_REQ = 1'b0; iHOST_WR = 1'b0;
      iHOST_ADDR = 6'd0; iHOST_WDATA = 8'd0; iCMD_READY = 1'b1;
      for (int i = 0; i < 64; i++) regs[i] = 8'($urandom);
      regs[0] = 8'hE5;
      tick(3);
      check_reset_outputs("por");

      // Startup delay then the configuration table
      push_cfg();
      iRST = 1'b0;
      n = 0;
      while (!oCMD_VALID && n < 200) begin
         tick(1);
         n++;
      end
      check("start_delay_cycles", 48'(n), 48'(START_DLY));
      check("cfg_done_early", 48'(oCFG_DONE), 48'd0);
      n = 0;
      while (!oCFG_DONE && n < 500) begin
         tick(1);
         n++;
      end
      check("cfg_done", 48'(oCFG_DONE), 48'd1);
      check("cfg_writes_left", 48'(exp_cmd_q.size()), 48'd0);

      // Reference sample
      push_sample(48'h10_01_20_02_30_03);
      s0 = smp_seen;
      int_edge();
      wait_drain("sample_drain");
      check("sample_pulses", 48'(smp_seen - s0), 48'd1);
      check("data_x", 48'(oDATA_X), 48'h0110);

      // Randomized mix of host accesses and samples
      for (int k = 0; k < 8; k++) begin
         lat = $urandom_range(1, 5);
         if ($urandom_range(0, 1) == 1) begin
            ad = 6'($urandom_range(1, 49));
            wd = 8'($urandom);
            host_access(1'($urandom), ad, wd);
         end else begin
            push_sample({$urandom, 16'($urandom)});
            int_edge();
         end
         wait_drain("random_drain");
      end
      lat = 3;

      // Host request and interrupt together: host goes first
      exp_cmd_q.push_back({1'b0, 6'h00, 8'h5A});
      exp_host_q.push_back(8'hE5);
      host_rdata_model = 8'hE5;
      push_sample({$urandom, 16'($urandom)});
      iHOST_WR = 1'b0; iHOST_ADDR = 6'h00; iHOST_WDATA = 8'h5A;
      iHOST_REQ = 1'b1; iG_INT2 = 1'b1;
      wait_ack("prio_ack_timeout");
      iHOST_REQ = 1'b0; iG_INT2 = 1'b0;
      wait_drain("prio_drain");
      check("prio_rdata", 48'(oHOST_RDATA), 48'hE5);

      // Three interrupts during one sample read
      lat = 8;
      check("overrun_before", 48'(oOVERRUN), 48'd0);
      push_sample({$urandom, 16'($urandom)});
      push_sample({$urandom, 16'($urandom)});
      s0 = smp_seen;
      c0 = cmd_seen;
      iG_INT2 = 1'b1;
      n = 0;
      while (cmd_seen == c0 && n < 50) begin
         tick(1);
         n++;
      end
      iG_INT2 = 1'b0;
      tick(3);
      repeat (3) int_edge();
      wait_drain("overrun_drain");
      tick(40);
      check("overrun_samples", 48'(smp_seen - s0), 48'd2);
      check("overrun_after", 48'(oOVERRUN), 48'd1);
      lat = 3;

      // Engine stalls: command must hold steady
      iCMD_READY = 1'b0;
      ad = 6'($urandom_range(1, 49));
      wd = 8'($urandom);
      exp_cmd_q.push_back({1'b1, ad, wd});
      exp_host_q.push_back(host_rdata_model);
      iHOST_WR = 1'b1; iHOST_ADDR = ad; iHOST_WDATA = wd; iHOST_REQ = 1'b1;
      n = 0;
      while (!oCMD_VALID && n < 20) begin
         tick(1);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         check("stall_cmd", {32'd0, oCMD_VALID, oCMD_WR, oCMD_ADDR, oCMD_WDATA}, {32'd0, 1'b1, 1'b1, ad, wd});
         tick(1);
      end
      iCMD_READY = 1'b1;
      tick(1);
      check("valid_drop_after_accept", 48'(oCMD_VALID), 48'd0);
      wait_ack("stall_ack_timeout");
      iHOST_REQ = 1'b0;
      wait_drain("stall_drain");

      // Reset in the middle of a sample read
      push_sample({$urandom, 16'($urandom)});
      s0 = smp_seen;
      c0 = smp_rsp_cnt;
      iG_INT2 = 1'b1;
      n = 0;
      while (smp_rsp_cnt < c0 + 3 && n < 200) begin
         tick(1);
         n++;
      end
      tick(1);
      iRST = 1'b1;
      iG_INT2 = 1'b0;
      exp_cmd_q.delete();
      exp_smp_q.delete();
      smp_bytes_q.delete();
      tick(3);
      check_reset_outputs("midrst");
      push_cfg();
      iRST = 1'b0;
      tick(2);
      int_edge();
      n = 0;
      while (!oCFG_DONE && n < 500) begin
         tick(1);
         n++;
      end
      check("recfg_done", 48'(oCFG_DONE), 48'd1);
      tick(40);
      check("recfg_writes_left", 48'(exp_cmd_q.size()), 48'd0);
      check("no_partial_sample", 48'(smp_seen - s0), 48'd0);
      check("data_after_reset", {oDATA_X, oDATA_Y, oDATA_Z}, 48'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
